// File: rtl/vga_framebuf.sv
// vga_framebuf: pixel framebuffer with write port, fill-clear and optional FRAMEBUF_DOUBLE_EN front/back buffering
module vga_framebuf #(
  parameter int H_BITS = 10,
  parameter int V_BITS = 9,
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int PIX_W  = 24
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [H_BITS-1:0] h_addr,
  input  logic [V_BITS-1:0] v_addr,
  input  logic              rd_en,
  output logic [PIX_W-1:0]  vga_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [H_BITS-1:0] wr_x,
  input  logic [V_BITS-1:0] wr_y,
  input  logic [PIX_W-1:0]  wr_data,
  input  logic              clr_req,
  input  logic [PIX_W-1:0]  clr_color,
  output logic              busy,
  input  logic              swap_req,
  input  logic              frame_start,
  output logic              front_sel,
  output logic [7:0]        drop_cnt
);
  localparam int AW = H_BITS + V_BITS;
  localparam logic [H_BITS-1:0] H_LAST = H_BITS'(H_RES - 1);
  localparam logic [V_BITS-1:0] V_LAST = V_BITS'(V_RES - 1);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state_q, state_d;
  logic [H_BITS-1:0] cx_q, cx_d;
  logic [V_BITS-1:0] cy_q, cy_d;
  logic [PIX_W-1:0] color_q, color_d, vga_data_q, vga_data_d, rd_word, wd;
  logic [7:0] drop_q, drop_d;
  logic front_q, front_d, pend_q, pend_d;
  logic idle, wr_fire, wr_in, rd_in, clr_last, we;
  logic [AW-1:0] wa, ra;
  logic [PIX_W-1:0] mem0 [2**AW];
`ifdef FRAMEBUF_DOUBLE_EN
  logic [PIX_W-1:0] mem1 [2**AW];
  logic swap_go;
`endif
  always_comb begin
    idle = state_q == IDLE;
    wr_fire = wr_valid && idle;
    wr_in = wr_x <= H_LAST && wr_y <= V_LAST;
    rd_in = rd_en && h_addr <= H_LAST && v_addr <= V_LAST;
    clr_last = cx_q == H_LAST && cy_q == V_LAST;
    ra = {v_addr, h_addr};
    we = resetn && (!idle || (wr_fire && wr_in));
    wa = idle ? {wr_y, wr_x} : {cy_q, cx_q};
    wd = idle ? wr_data : color_q;
    state_d = idle ? (clr_req ? CLEAR : IDLE) : (clr_last ? IDLE : CLEAR);
    color_d = idle && clr_req ? clr_color : color_q;
    cx_d = idle || cx_q == H_LAST ? '0 : cx_q + 1'b1;
    cy_d = idle ? '0 : (cx_q == H_LAST ? cy_q + 1'b1 : cy_q);
    drop_d = wr_fire && !wr_in && drop_q != 8'hff ? drop_q + 8'd1 : drop_q;
`ifdef FRAMEBUF_DOUBLE_EN
    swap_go = frame_start && pend_q && idle;
    front_d = front_q ^ swap_go;
    pend_d = swap_req || (pend_q && !swap_go);
    rd_word = front_q ? mem1[ra] : mem0[ra];
`else
    front_d = 1'b0;
    pend_d = 1'b0;
    rd_word = mem0[ra];
`endif
    vga_data_d = rd_in ? rd_word : '0;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      cx_q <= '0;
      cy_q <= '0;
      color_q <= '0;
      vga_data_q <= '0;
      drop_q <= '0;
      front_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cx_q <= cx_d;
      cy_q <= cy_d;
      color_q <= color_d;
      vga_data_q <= vga_data_d;
      drop_q <= drop_d;
      front_q <= front_d;
      pend_q <= pend_d;
    end
  end
`ifdef FRAMEBUF_DOUBLE_EN
  // the back buffer is whichever one is not being displayed
  always_ff @(posedge clk) begin
    if (we && front_q) mem0[wa] <= wd;
    if (we && !front_q) mem1[wa] <= wd;
  end
`else
  logic unused_ok;
  assign unused_ok = ^{swap_req, frame_start, pend_q};
  always_ff @(posedge clk) begin
    if (we) mem0[wa] <= wd;
  end
`endif
  assign vga_data = vga_data_q;
  assign wr_ready = idle;
  assign busy = !idle;
  assign front_sel = front_q;
  assign drop_cnt = drop_q;
endmodule

// File: tb/tb_vga_framebuf.sv
// tb_vga_framebuf: table vectors, corner sequences and random traffic against a pixel-array reference model
module tb_vga_framebuf;
  localparam int HB = 5, VB = 4, HR = 20, VR = 12, PW = 24, N = HR * VR;
  localparam logic [PW-1:0] C0 = 24'h101010;
`ifdef FRAMEBUF_DOUBLE_EN
  localparam bit DBL = 1'b1;
`else
  localparam bit DBL = 1'b0;
`endif
  localparam logic [PW-1:0] AFTER_WR = DBL ? C0 : 24'h777777;
  logic clk = 1'b0, resetn;
  logic [HB-1:0] h_addr, wr_x;
  logic [VB-1:0] v_addr, wr_y;
  logic rd_en, wr_valid, wr_ready, clr_req, busy, swap_req, frame_start, front_sel;
  logic [PW-1:0] vga_data, wr_data, clr_color;
  logic [7:0] drop_cnt;
  vga_framebuf #(.H_BITS(HB), .V_BITS(VB), .H_RES(HR), .V_RES(VR), .PIX_W(PW)) dut (
    .clk(clk), .resetn(resetn), .h_addr(h_addr), .v_addr(v_addr), .rd_en(rd_en),
    .vga_data(vga_data), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x),
    .wr_y(wr_y), .wr_data(wr_data), .clr_req(clr_req), .clr_color(clr_color),
    .busy(busy), .swap_req(swap_req), .frame_start(frame_start),
    .front_sel(front_sel), .drop_cnt(drop_cnt));
  always #5 clk = ~clk;
  int checks = 0, passed = 0;
  logic [PW-1:0] fb [2][N];
  bit mbusy, mf, mpend;
  int cidx, mdrop;
  logic [PW-1:0] ccol;
  typedef struct {
    int wx; int wy; logic [PW-1:0] wd;
    int rx; int ry; bit ren;
    logic [PW-1:0] ev; int ed;
  } vec_t;
  vec_t tv[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic quiet();
    rd_en = 0; h_addr = '0; v_addr = '0;
    wr_valid = 0; wr_x = '0; wr_y = '0; wr_data = '0;
    clr_req = 0; clr_color = '0; swap_req = 0; frame_start = 0;
  endtask

  // one clock: advance the reference model, then compare every output against it
  task automatic cyc();
    logic [PW-1:0] e;
    int bk;
    e = (rd_en && int'(h_addr) < HR && int'(v_addr) < VR) ? fb[mf][int'(v_addr) * HR + int'(h_addr)] : '0;
    bk = DBL ? int'(!mf) : 0;
    if (!resetn) begin
      mbusy = 0; mf = 0; mpend = 0; mdrop = 0; e = '0;
    end else begin
      if (!mbusy) begin
        if (wr_valid) begin
          if (int'(wr_x) < HR && int'(wr_y) < VR) fb[bk][int'(wr_y) * HR + int'(wr_x)] = wr_data;
          else if (mdrop < 255) mdrop++;
        end
        if (DBL && frame_start && mpend) begin mf = !mf; mpend = 0; end
        if (clr_req) begin mbusy = 1; cidx = 0; ccol = clr_color; end
      end else begin
        fb[bk][cidx] = ccol;
        cidx++;
        if (cidx == N) mbusy = 0;
      end
      if (DBL && swap_req) mpend = 1;
    end
    @(posedge clk);
    #1;
    chk("vga_data", vga_data, e);
    chk("busy", busy, mbusy);
    chk("wr_ready", wr_ready, !mbusy);
    chk("drop_cnt", drop_cnt, mdrop);
    chk("front_sel", front_sel, mf);
  endtask

  task automatic run_clear(input logic [PW-1:0] c, input string name);
    int n = 0, bad = 0;
    clr_req = 1; clr_color = c;
    cyc();
    clr_req = 0; wr_valid = 0;
    while (busy && n < N + 8) begin
      if (wr_ready !== 1'b0) bad++;
      cyc();
      n++;
    end
    chk({name, "_cycles"}, n, N);
    chk({name, "_ready_low"}, bad, 0);
  endtask

  task automatic do_swap();
    swap_req = 1; cyc(); swap_req = 0;
    frame_start = 1; cyc(); frame_start = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cb;
    tv[0] = '{5, 7, 24'hFF0000, 5, 7, 1, 24'hFF0000, 0};
    tv[1] = '{0, 0, 24'h111111, 0, 0, 1, 24'h111111, 0};
    tv[2] = '{19, 11, 24'h0000FF, 19, 11, 1, 24'h0000FF, 0};
    tv[3] = '{25, 3, 24'h123456, 25, 3, 1, 24'h000000, 1};
    tv[4] = '{3, 3, 24'hABCDEF, 3, 3, 0, 24'h000000, 1};
    tv[5] = '{2, 2, 24'h222222, 20, 2, 1, 24'h000000, 1};
    tv[6] = '{4, 4, 24'h333333, 4, 12, 1, 24'h000000, 1};
    tv[7] = '{6, 6, 24'h444444, 6, 5, 1, C0, 1};
    tv[8] = '{10, 15, 24'h555555, 10, 15, 1, 24'h000000, 2};
    tv[9] = '{7, 8, 24'h666666, 7, 8, 1, 24'h666666, 2};
    quiet();
    resetn = 0; mbusy = 0; mf = 0; mpend = 0; mdrop = 0; cidx = 0; ccol = '0;
    cyc(); cyc();
    chk("rst_vga", vga_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", wr_ready, 1);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_front", front_sel, 0);
    resetn = 1;
    run_clear(C0, "init_clear");
`ifdef FRAMEBUF_DOUBLE_EN
    do_swap();
    chk("init_swap_front", front_sel, 1);
    run_clear(C0, "init_clear2");
`endif
    foreach (tv[i]) begin
      wr_valid = 1; wr_x = HB'(tv[i].wx); wr_y = VB'(tv[i].wy); wr_data = tv[i].wd;
      cyc();
      wr_valid = 0;
`ifdef FRAMEBUF_DOUBLE_EN
      do_swap();
`endif
      rd_en = tv[i].ren; h_addr = HB'(tv[i].rx); v_addr = VB'(tv[i].ry);
      cyc();
      chk($sformatf("vec%0d_vga", i), vga_data, tv[i].ev);
      chk($sformatf("vec%0d_drop", i), drop_cnt, tv[i].ed);
      rd_en = 0;
`ifdef FRAMEBUF_DOUBLE_EN
      do_swap();
`endif
    end
    wr_valid = 1; wr_x = 8; wr_y = 8; wr_data = 24'h777777;
    rd_en = 1; h_addr = 8; v_addr = 8;
    cyc();
    chk("same_cycle_old", vga_data, C0);
    wr_valid = 0;
    cyc();
    chk("after_write", vga_data, AFTER_WR);
    quiet();
    for (int i = 0; i < 800; i++) begin
      wr_valid = 1'($urandom_range(0, 1));
      wr_x = HB'($urandom_range(0, HR + 3)); wr_y = VB'($urandom_range(0, VR + 1));
      wr_data = PW'($urandom);
      rd_en = $urandom_range(0, 3) != 0;
      h_addr = HB'($urandom_range(0, HR)); v_addr = VB'($urandom_range(0, VR));
      swap_req = $urandom_range(0, 15) == 0;
      frame_start = $urandom_range(0, 7) == 0;
      cyc();
    end
    quiet();
    wr_valid = 1; wr_x = 1; wr_y = 1; wr_data = 24'hABCDEF;
    run_clear(24'h00FF00, "clear_green");
`ifdef FRAMEBUF_DOUBLE_EN
    do_swap();
`endif
    rd_en = 1; h_addr = 1; v_addr = 1; cyc();
    chk("green_over_write", vga_data, 24'h00FF00);
    h_addr = 19; v_addr = 11; cyc();
    chk("green_last_px", vga_data, 24'h00FF00);
    h_addr = 0; v_addr = 0; cyc();
    chk("green_first_px", vga_data, 24'h00FF00);
    rd_en = 0;
`ifdef FRAMEBUF_DOUBLE_EN
    begin
      bit f0;
      int n;
      f0 = mf; n = 0;
      clr_req = 1; clr_color = 24'h0000CC; cyc(); clr_req = 0;
      swap_req = 1; cyc(); swap_req = 0;
      frame_start = 1; cyc(); frame_start = 0;
      chk("swap_deferred", front_sel, f0);
      while (busy && n < N + 8) begin cyc(); n++; end
      chk("swap_still_deferred", front_sel, f0);
      frame_start = 1; cyc(); frame_start = 0;
      chk("swap_after_clear", front_sel, !f0);
      rd_en = 1; h_addr = 3; v_addr = 4; cyc();
      chk("swap_new_visible", vga_data, 24'h0000CC);
      rd_en = 0;
    end
`endif
    cb = DBL ? int'(!mf) : 0;
    clr_req = 1; clr_color = 24'h0000AA; cyc(); clr_req = 0;
    repeat (30) cyc();
    resetn = 0; cyc(); resetn = 1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_ready", wr_ready, 1);
    if (cb != int'(mf)) do_swap();
    rd_en = 1; h_addr = 9; v_addr = 1; cyc();
    chk("partial_cleared", vga_data, 24'h0000AA);
    h_addr = 10; cyc();
    h_addr = 5; v_addr = 7; cyc();
    rd_en = 0;
    wr_valid = 1; wr_x = 25; wr_y = 3; wr_data = 24'hDEAD00;
    repeat (150) cyc();
    chk("drop_150", drop_cnt, 150);
    repeat (150) cyc();
    chk("drop_saturated", drop_cnt, 255);
    chk("drop_ready", wr_ready, 1);
    quiet();
    rd_en = 1; h_addr = 11; v_addr = 3; cyc();
    rd_en = 0; cyc();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/vga_framebuf.md
VGA_FRAMEBUF -- requirements
Module: vga_framebuf

Interface
REQ-001 SHALL have parameter: H_BITS, 10, horizontal address width.
REQ-002 SHALL have parameter: V_BITS, 9, vertical address width.
REQ-003 SHALL have parameter: H_RES, 640, visible pixels per line.
REQ-004 SHALL have parameter: V_RES, 480, visible lines per frame.
REQ-005 SHALL have parameter: PIX_W, 24, pixel data width.
REQ-006 SHALL have port: clk  in  1  single clock, all logic on rising edge.
REQ-007 SHALL have port: resetn  in  1  synchronous, active-low reset.
REQ-008 SHALL have ports: h_addr in H_BITS, v_addr in V_BITS, rd_en in 1  display-side pixel request from vga_ctrl.
REQ-009 SHALL have port: vga_data  out  PIX_W  registered pixel to vga_ctrl.
REQ-010 SHALL have ports: wr_valid in 1, wr_ready out 1, wr_x in H_BITS, wr_y in V_BITS, wr_data in PIX_W  pixel write channel.
REQ-011 SHALL have ports: clr_req in 1, clr_color in PIX_W, busy out 1  clear command and status.
REQ-012 SHALL have ports: swap_req in 1, frame_start in 1, front_sel out 1  buffer swap control.
REQ-013 SHALL have port: drop_cnt  out  8  count of dropped out-of-range writes.

Function
REQ-014 SHALL address memory as {y, x}; depth 2^(H_BITS+V_BITS) words of PIX_W per buffer.
REQ-015 SHALL register vga_data with 1-cycle latency from h_addr/v_addr/rd_en.
REQ-016 SHALL drive vga_data 0 next cycle when rd_en=0, h_addr>=H_RES or v_addr>=V_RES.
REQ-017 SHALL accept a write on the edge where wr_valid=1 and wr_ready=1; data becomes readable from the following cycle (same-cycle read of same address returns old data).
REQ-018 SHALL complete the handshake for out-of-range writes (wr_x>=H_RES or wr_y>=V_RES) without storing, and increment drop_cnt, saturating at 255.
REQ-019 SHALL implement FSM IDLE/CLEAR; IDLE: wr_ready=1, busy=0; CLEAR: wr_ready=0, busy=1.
REQ-020 SHALL, on clr_req=1 in IDLE, latch clr_color, zero the pixel counter, enter CLEAR next cycle.
REQ-021 SHALL, in CLEAR, write the latched colour to one in-range pixel per cycle, x fastest then y, H_RES*V_RES cycles total, returning to IDLE the cycle after pixel (H_RES-1, V_RES-1).
REQ-022 SHALL ignore clr_req while in CLEAR.
REQ-023 SHALL, when wr_valid and clr_req coincide in IDLE, accept the write, then clear (clear colour wins).
REQ-024 SHALL direct writes and clears to the back buffer and reads to the front buffer (see Configuration).

Reset
REQ-025 SHALL on resetn=0 at a clock edge set FSM=IDLE, counter=0, vga_data=0, drop_cnt=0, front_sel=0, swap pending=0; memory contents unchanged.
REQ-026 SHALL abort a clear in progress on reset; partially cleared pixels stay written.

Configuration
REQ-027 SHALL, with FRAMEBUF_DOUBLE_EN defined, instantiate two buffers; swap_req sets a pending flag; on frame_start with pending=1 and FSM=IDLE, front_sel toggles and pending clears; during CLEAR the swap defers to the next qualifying frame_start.
REQ-028 SHALL, without FRAMEBUF_DOUBLE_EN, instantiate one buffer shared by read and write, ignore swap_req/frame_start, and hold front_sel=0.

Verification
REQ-029 SHALL cover: write (5,7)=0xFF0000, read h=5,v=7 rd_en=1 -> vga_data=0xFF0000 one cycle later.
REQ-030 SHALL cover: write wr_x=700 -> wr_ready handshake completes, drop_cnt=1, memory unchanged; 300 such writes -> drop_cnt=255.
REQ-031 SHALL cover: clr_req with clr_color=0x00FF00 -> busy=1, wr_ready=0 for 307200 cycles, then any in-range pixel reads 0x00FF00.
REQ-032 SHALL cover: rd_en=0 or h_addr=640 -> vga_data=0; resetn=0 mid-clear -> busy=0, wr_ready=1 next cycle.
REQ-033 SHALL cover (FRAMEBUF_DOUBLE_EN): write back buffer, swap_req, frame_start -> front_sel=1 and new pixel visible; swap_req during clear -> front_sel toggles only at first frame_start after busy=0.
